// File: rtl/banked_pixel_mem_pkg.sv
// ---------------------------------------------------------------------------
// Package pix_mem_pkg
// Purpose : shared types and constant helpers for the banked pixel store.
//           Holds the load FSM state type, the default pixel width and
//           elaboration-time helpers that turn flat pixel counts into
//           bank / offset constants.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package pix_mem_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  function automatic int total_pix(input int num_banks, input int bank_depth);
    return num_banks * bank_depth;
  endfunction

  // These are only meant for constants; the datapath never divides.
  function automatic int bank_of(input int addr, input int bank_depth);
    return addr / bank_depth;
  endfunction

  function automatic int offset_of(input int addr, input int bank_depth);
    return addr % bank_depth;
  endfunction

endpackage

// File: rtl/banked_pixel_mem_if.sv
// ---------------------------------------------------------------------------
// Interface banked_pixel_mem_if
// Purpose : bundles the frame-load stream and the display read port of the
//           banked pixel store.
// Signals : load_start, ld_valid/ld_ready/ld_data/ld_last, load_done,
//           frame_ok (load side); rd_req/rd_addr, rd_valid/rd_data/rd_err
//           (read side).
// Modports: master - the client that loads frames and issues reads
//           slave  - the pixel store itself
// ---------------------------------------------------------------------------
interface banked_pixel_mem_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 18
) ();

  logic              load_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [PIX_W-1:0]  ld_data;
  logic              ld_last;
  logic              load_done;
  logic              frame_ok;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [PIX_W-1:0]  rd_data;
  logic              rd_err;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, rd_req, rd_addr,
    input  ld_ready, load_done, frame_ok, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, rd_req, rd_addr,
    output ld_ready, load_done, frame_ok, rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/banked_pixel_mem_bank.sv
// ---------------------------------------------------------------------------
// Module pix_bank
// Purpose : one bank of pixel storage; a synchronous RAM with one write port
//           and one registered read port (read data appears the cycle after
//           the address is presented). Contents are never reset.
// Ports   : clk    - clock
//           we     - write enable
//           waddr  - write offset within the bank
//           wdata  - pixel to write
//           raddr  - read offset within the bank
//           rdata  - registered read pixel
// ---------------------------------------------------------------------------
module pix_bank #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 51200,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  // Plain RAM template without reset so it maps onto block RAM; a read of
  // the address being written returns the old word, which the top never
  // exposes because such reads are always flagged as errors.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/banked_pixel_mem.sv
// ---------------------------------------------------------------------------
// Module banked_pixel_mem
// Purpose : frame-buffer pixel store split into NUM_BANKS equal banks. A
//           frame is loaded at run time over a valid/ready stream and read
//           back by the display through a linear address space with a
//           request/valid port.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - banked_pixel_mem_if.slave (load stream + read port)
// Config  : PIX_MEM_OUTREG_EN - when defined, adds an output register stage
//           so the read latency becomes 2; the load path is unchanged.
// ---------------------------------------------------------------------------
module banked_pixel_mem
  import pix_mem_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int BANK_DEPTH = 51200,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_W     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  banked_pixel_mem_if.slave  bus
);

  localparam int TOTAL  = total_pix(NUM_BANKS, BANK_DEPTH);
  localparam int OFF_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(bank_of(TOTAL - 1, BANK_DEPTH));
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(offset_of(TOTAL - 1, BANK_DEPTH));
  localparam logic [OFF_W-1:0]  OFF_MAX   = OFF_W'(BANK_DEPTH - 1);
  // One bit wider than the address so TOTAL == 2**ADDR_W still compares right.
  localparam logic [ADDR_W:0]   TOTAL_X   = (ADDR_W + 1)'(TOTAL);

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                frame_ok_q, frame_ok_d;
  logic                load_done_q, load_done_d;
  logic                ld_accept;
  logic                final_beat;
  logic [NUM_BANKS-1:0] bank_we;

  logic                rd_vld_q, rd_vld_d;
  logic                rd_err_q, rd_err_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]   rd_base;
  logic [OFF_W-1:0]    rd_off;
  logic [PIX_W-1:0]    bank_dout [NUM_BANKS];

  logic                resp_valid;
  logic                resp_err;
  logic [PIX_W-1:0]    resp_data;

  // State register for the load FSM and the write pointer. The pointer is
  // kept as a bank counter plus an offset counter so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      off_q       <= '0;
      frame_ok_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      off_q       <= off_d;
      frame_ok_q  <= frame_ok_d;
      load_done_q <= load_done_d;
    end
  end

  // Next-state logic. load_start wins over everything, including a beat
  // accepted in the same cycle, so a restart never reports a stale frame.
  // The frame ends on ld_last or when the pointer reaches the last pixel.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    off_d       = off_q;
    frame_ok_d  = frame_ok_q;
    load_done_d = 1'b0;
    ld_accept   = (state_q == LOAD) && bus.ld_valid;
    final_beat  = ld_accept && (bus.ld_last ||
                  ((bank_q == LAST_BANK) && (off_q == LAST_OFF)));

    if (bus.load_start) begin
      state_d    = LOAD;
      bank_d     = '0;
      off_d      = '0;
      frame_ok_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (ld_accept) begin
            if (off_q == OFF_MAX) begin
              off_d  = '0;
              bank_d = bank_q + 1'b1;
            end else begin
              off_d  = off_q + 1'b1;
            end
            if (final_beat) begin
              state_d     = READY;
              load_done_d = 1'b1;
              frame_ok_d  = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Steer the accepted beat to the bank the write counter points at.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_we[k] = ld_accept && (bank_q == BANK_W'(k));
    end
  end

  // Read address decode: a compare chain against the bank base constants
  // picks the bank, and subtracting that base gives the offset. The request
  // is flagged as an error up front if it is out of range or no complete
  // frame is stored, which also covers reads racing an in-progress load.
  always_comb begin
    rd_bank_d = '0;
    rd_base   = '0;
    for (int k = 1; k < NUM_BANKS; k++) begin
      if ({1'b0, bus.rd_addr} >= (ADDR_W + 1)'(k * BANK_DEPTH)) begin
        rd_bank_d = BANK_W'(k);
        rd_base   = ADDR_W'(k * BANK_DEPTH);
      end
    end
    rd_off   = OFF_W'(bus.rd_addr - rd_base);
    rd_vld_d = bus.rd_req;
    rd_err_d = bus.rd_req && (!frame_ok_q || ({1'b0, bus.rd_addr} >= TOTAL_X));
  end

  // Read request pipeline register, aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_err_q  <= rd_err_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    pix_bank #(
      .PIX_W (PIX_W),
      .DEPTH (BANK_DEPTH),
      .AW    (OFF_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (off_q),
      .wdata (bus.ld_data),
      .raddr (rd_off),
      .rdata (bank_dout[g])
    );
  end

  // Response mux: data only when a valid, non-error response is due; all
  // response outputs sit at zero otherwise.
  always_comb begin
    resp_valid = rd_vld_q;
    resp_err   = rd_vld_q && rd_err_q;
    resp_data  = '0;
    if (rd_vld_q && !rd_err_q) begin
      resp_data = bank_dout[rd_bank_q];
    end
  end

`ifdef PIX_MEM_OUTREG_EN
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  // Extra output stage to ease timing on the RAM-to-output path; all three
  // response signals move together so the port protocol is unchanged.
  always_comb begin
    out_valid_d = resp_valid;
    out_err_d   = resp_err;
    out_data_d  = resp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.rd_valid = out_valid_q;
  assign bus.rd_err   = out_err_q;
  assign bus.rd_data  = out_data_q;
`else
  assign bus.rd_valid = resp_valid;
  assign bus.rd_err   = resp_err;
  assign bus.rd_data  = resp_data;
`endif

  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.load_done = load_done_q;
  assign bus.frame_ok  = frame_ok_q;

endmodule
